// File: rtl/dsram_arb.sv
// dsram_arb: fixed-priority arbiter sharing the data SRAM between the core LSU port and a debug port.
// Optional access statistics are enabled with `define DSRAM_ARB_STAT_EN.
module dsram_arb #(
   parameter int AW         = 8,
   parameter int STARVE_MAX = 16
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [15:0]   dat_a,
   input  logic [3:0]    dat_we,
   input  logic [31:0]   dat_wd,
   input  logic [3:0]    dat_re,
   output logic [31:0]   dat_rd,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [3:0]    dbg_be,
   input  logic [AW-1:0] dbg_a,
   input  logic [31:0]   dbg_wd,
   output logic          dbg_gnt,
   output logic          dbg_rvalid,
   output logic [31:0]   dbg_rd,
   output logic          dbg_starve,
   input  logic          dbg_starve_clr,
   output logic [AW-1:0] sram_a,
   output logic [3:0]    sram_we,
   output logic [31:0]   sram_wd,
   output logic [3:0]    sram_re,
`ifdef DSRAM_ARB_STAT_EN
   output logic [31:0]   stat_core,
   output logic [31:0]   stat_dbg,
   output logic [31:0]   stat_conf,
`endif
   input  logic [31:0]   sram_rd
);

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_CORE = 2'd1;
   localparam logic [1:0] OWN_DBGR = 2'd2;
   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   logic          core_req_s;
   logic          dbg_gnt_s;
   logic [3:0]    we_s;
   logic [3:0]    re_s;
   logic [AW-1:0] a_hold_r;
   logic [31:0]   wd_hold_r;
   logic [1:0]    own_r;
   logic [31:0]   hold_rd_r;
   logic [7:0]    wait_cnt_r;
   logic [7:0]    wait_nx_s;
   logic          starve_r;
   logic          unused_s;

   assign core_req_s = (|dat_we) | (|dat_re);
   assign dbg_gnt_s  = dbg_req & ~core_req_s;
   assign dbg_gnt    = dbg_gnt_s;
   assign unused_s   = ^{dat_a[1:0], dat_a[15:AW+2]};

   // SRAM port mux; address and write data hold their last value when idle
   always_comb begin
      sram_a  = a_hold_r;
      sram_wd = wd_hold_r;
      we_s    = 4'h0;
      re_s    = 4'h0;
      if (core_req_s) begin
         sram_a  = dat_a[AW+1:2];
         sram_wd = dat_wd;
         we_s    = dat_we;
         re_s    = dat_re;
      end else if (dbg_gnt_s) begin
         sram_a  = dbg_a;
         sram_wd = dbg_wd;
         if (dbg_we) begin
            we_s = dbg_be;
         end else begin
            re_s = dbg_be;
         end
      end else begin
         we_s = 4'h0;
         re_s = 4'h0;
      end
   end

   // Strobes are suppressed while reset is asserted
   always_comb begin
      if (rstn) begin
         sram_we = we_s;
         sram_re = re_s;
      end else begin
         sram_we = 4'h0;
         sram_re = 4'h0;
      end
   end

   // Read-data routing by owner of the previous access
   always_comb begin
      if (own_r == OWN_CORE) begin
         dat_rd = sram_rd;
      end else begin
         dat_rd = hold_rd_r;
      end
      if (own_r == OWN_DBGR) begin
         dbg_rvalid = 1'b1;
         dbg_rd     = sram_rd;
      end else begin
         dbg_rvalid = 1'b0;
         dbg_rd     = 32'h0;
      end
   end

   // Next starvation count, saturating
   always_comb begin
      if (dbg_req && !dbg_gnt_s) begin
         if (wait_cnt_r == 8'hFF) begin
            wait_nx_s = 8'hFF;
         end else begin
            wait_nx_s = wait_cnt_r + 8'd1;
         end
      end else begin
         wait_nx_s = 8'h00;
      end
   end

   // Owner tracking, read hold, port hold and starvation state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         own_r      <= OWN_NONE;
         hold_rd_r  <= 32'h0;
         a_hold_r   <= '0;
         wd_hold_r  <= 32'h0;
         wait_cnt_r <= 8'h00;
         starve_r   <= 1'b0;
      end else begin
         if (core_req_s) begin
            own_r <= OWN_CORE;
         end else if (dbg_gnt_s && !dbg_we) begin
            own_r <= OWN_DBGR;
         end else begin
            own_r <= OWN_NONE;
         end
         if (own_r == OWN_CORE) begin
            hold_rd_r <= sram_rd;
         end
         a_hold_r   <= sram_a;
         wd_hold_r  <= sram_wd;
         wait_cnt_r <= wait_nx_s;
         // Clear wins over a coincident set
         if (dbg_starve_clr) begin
            starve_r <= 1'b0;
         end else if (wait_nx_s == STARVE_LIM && wait_cnt_r != STARVE_LIM) begin
            starve_r <= 1'b1;
         end
      end
   end

   assign dbg_starve = starve_r;

`ifdef DSRAM_ARB_STAT_EN
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [31:0] stat_core_r;
   logic [31:0] stat_dbg_r;
   logic [31:0] stat_conf_r;

   // Saturating access statistics
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_core_r <= 32'h0;
         stat_dbg_r  <= 32'h0;
         stat_conf_r <= 32'h0;
      end else begin
         if (core_req_s) begin
            stat_core_r <= sat_inc32(stat_core_r);
         end
         if (dbg_gnt_s) begin
            stat_dbg_r <= sat_inc32(stat_dbg_r);
         end
         if (dbg_req && core_req_s) begin
            stat_conf_r <= sat_inc32(stat_conf_r);
         end
      end
   end

   assign stat_core = stat_core_r;
   assign stat_dbg  = stat_dbg_r;
   assign stat_conf = stat_conf_r;
`endif

endmodule

// File: tb/tb_dsram_arb.sv
// tb_dsram_arb: directed self-checking bench for dsram_arb with a behavioural SRAM model.
module tb_dsram_arb;

   logic        clk = 1'b0;
   logic        rstn;
   logic [15:0] dat_a;
   logic [3:0]  dat_we;
   logic [31:0] dat_wd;
   logic [3:0]  dat_re;
   logic [31:0] dat_rd;
   logic        dbg_req;
   logic        dbg_we;
   logic [3:0]  dbg_be;
   logic [7:0]  dbg_a;
   logic [31:0] dbg_wd;
   logic        dbg_gnt;
   logic        dbg_rvalid;
   logic [31:0] dbg_rd;
   logic        dbg_starve;
   logic        dbg_starve_clr;
   logic [7:0]  sram_a;
   logic [3:0]  sram_we;
   logic [31:0] sram_wd;
   logic [3:0]  sram_re;
   logic [31:0] sram_rd;
`ifdef DSRAM_ARB_STAT_EN
   logic [31:0] stat_core;
   logic [31:0] stat_dbg;
   logic [31:0] stat_conf;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mem [0:255];

   dsram_arb #(.AW(8), .STARVE_MAX(4)) dut (
      .clk(clk), .rstn(rstn),
      .dat_a(dat_a), .dat_we(dat_we), .dat_wd(dat_wd), .dat_re(dat_re), .dat_rd(dat_rd),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_be(dbg_be), .dbg_a(dbg_a), .dbg_wd(dbg_wd),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rd(dbg_rd),
      .dbg_starve(dbg_starve), .dbg_starve_clr(dbg_starve_clr),
      .sram_a(sram_a), .sram_we(sram_we), .sram_wd(sram_wd), .sram_re(sram_re),
`ifdef DSRAM_ARB_STAT_EN
      .stat_core(stat_core), .stat_dbg(stat_dbg), .stat_conf(stat_conf),
`endif
      .sram_rd(sram_rd)
   );

   always #5 clk = ~clk;

   // Single-port SRAM model: byte writes, registered read
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (sram_we[b]) mem[sram_a][8*b +: 8] <= sram_wd[8*b +: 8];
      end
      if (|sram_re) sram_rd <= mem[sram_a];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      dat_a = 16'h0; dat_we = 4'h0; dat_wd = 32'h0; dat_re = 4'h0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_be = 4'h0; dbg_a = 8'h0; dbg_wd = 32'h0;
      dbg_starve_clr = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++; if (dat_rd !== 32'h0) begin n_bad++; $display("FAIL reset_dat_rd got %h exp %h", dat_rd, 32'h0); end
      n_cmp++; if (dbg_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid got %b exp 0", dbg_rvalid); end
      n_cmp++; if (dbg_rd !== 32'h0) begin n_bad++; $display("FAIL reset_dbg_rd got %h exp 0", dbg_rd); end
      n_cmp++; if (dbg_starve !== 1'b0) begin n_bad++; $display("FAIL reset_starve got %b exp 0", dbg_starve); end
      n_cmp++; if (sram_a !== 8'h00 || sram_we !== 4'h0 || sram_re !== 4'h0) begin
         n_bad++; $display("FAIL reset_port got a=%h we=%h re=%h exp 00/0/0", sram_a, sram_we, sram_re); end
   endtask

   task automatic test_core_rw();
      dat_a = 16'h0010; dat_we = 4'hF; dat_wd = 32'hDEADBEEF;
      #1;
      n_cmp++; if (sram_a !== 8'h04 || sram_we !== 4'hF || sram_wd !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL core_wr_port got a=%h we=%h wd=%h exp 04/F/DEADBEEF", sram_a, sram_we, sram_wd); end
      step();
      dat_we = 4'h0; dat_re = 4'hF;
      #1;
      n_cmp++; if (sram_a !== 8'h04 || sram_re !== 4'hF || sram_we !== 4'h0) begin
         n_bad++; $display("FAIL core_rd_port got a=%h re=%h we=%h exp 04/F/0", sram_a, sram_re, sram_we); end
      step();
      n_cmp++; if (dat_rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL core_rd_data got %h exp DEADBEEF", dat_rd); end
      dat_re = 4'h0; dat_a = 16'h00F0;
      #1;
      n_cmp++; if (sram_a !== 8'h04 || sram_re !== 4'h0) begin
         n_bad++; $display("FAIL idle_hold_addr got a=%h re=%h exp 04/0", sram_a, sram_re); end
      step();
      n_cmp++; if (dat_rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL core_rd_stable got %h exp DEADBEEF", dat_rd); end
   endtask

   task automatic test_idle_dbg();
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_a = 8'h20; dbg_be = 4'h3; dbg_wd = 32'h12345678;
      #1;
      n_cmp++; if (dbg_gnt !== 1'b1 || sram_we !== 4'h3 || sram_re !== 4'h0 || sram_a !== 8'h20) begin
         n_bad++; $display("FAIL dbg_wr_gnt got gnt=%b we=%h re=%h a=%h exp 1/3/0/20", dbg_gnt, sram_we, sram_re, sram_a); end
      step();
      n_cmp++; if (dbg_rvalid !== 1'b0) begin n_bad++; $display("FAIL dbg_wr_norvalid got %b exp 0", dbg_rvalid); end
      dbg_we = 1'b0; dbg_be = 4'hF;
      #1;
      n_cmp++; if (dbg_gnt !== 1'b1 || sram_re !== 4'hF) begin
         n_bad++; $display("FAIL dbg_rd_gnt got gnt=%b re=%h exp 1/F", dbg_gnt, sram_re); end
      step();
      n_cmp++; if (dbg_rvalid !== 1'b1 || dbg_rd !== 32'h00005678) begin
         n_bad++; $display("FAIL dbg_rd_data got v=%b rd=%h exp 1/00005678", dbg_rvalid, dbg_rd); end
      n_cmp++; if (dat_rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL dbg_rd_core_undisturbed got %h exp DEADBEEF", dat_rd); end
      dbg_req = 1'b0;
      step();
      n_cmp++; if (dbg_rvalid !== 1'b0 || dbg_rd !== 32'h0) begin
         n_bad++; $display("FAIL dbg_rvalid_drop got v=%b rd=%h exp 0/0", dbg_rvalid, dbg_rd); end
   endtask

   task automatic test_conflict();
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_a = 8'h20; dbg_be = 4'hF;
      dat_a = 16'h0010; dat_re = 4'hF;
      for (int k = 1; k <= 3; k++) begin
         #1;
         n_cmp++; if (dbg_gnt !== 1'b0 || sram_a !== 8'h04) begin
            n_bad++; $display("FAIL conflict_gnt[%0d] got gnt=%b a=%h exp 0/04", k, dbg_gnt, sram_a); end
         step();
         n_cmp++; if (dat_rd !== 32'hDEADBEEF || dbg_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL conflict_rd[%0d] got rd=%h v=%b exp DEADBEEF/0", k, dat_rd, dbg_rvalid); end
      end
      dat_re = 4'h0;
      #1;
      n_cmp++; if (dbg_gnt !== 1'b1) begin n_bad++; $display("FAIL conflict_gnt4 got %b exp 1", dbg_gnt); end
      n_cmp++; if (dbg_starve !== 1'b0) begin n_bad++; $display("FAIL conflict_nostarve got %b exp 0", dbg_starve); end
      step();
      dbg_req = 1'b0;
      n_cmp++; if (dbg_rvalid !== 1'b1 || dbg_rd !== 32'h00005678 || dat_rd !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL conflict_ret got v=%b drd=%h crd=%h exp 1/00005678/DEADBEEF", dbg_rvalid, dbg_rd, dat_rd); end
      step();
   endtask

   task automatic test_starve();
      logic exp_st;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_a = 8'h30; dbg_be = 4'hF; dbg_wd = 32'h0;
      dat_a = 16'h0010; dat_re = 4'hF;
      for (int k = 1; k <= 6; k++) begin
         step();
         exp_st = (k >= 4) ? 1'b1 : 1'b0;
         n_cmp++; if (dbg_starve !== exp_st) begin
            n_bad++; $display("FAIL starve_edge[%0d] got %b exp %b", k, dbg_starve, exp_st); end
      end
      dat_re = 4'h0;
      #1;
      n_cmp++; if (dbg_gnt !== 1'b1) begin n_bad++; $display("FAIL starve_gnt got %b exp 1", dbg_gnt); end
      step();
      n_cmp++; if (dbg_starve !== 1'b1) begin n_bad++; $display("FAIL starve_sticky got %b exp 1", dbg_starve); end
      dbg_req = 1'b0; dbg_starve_clr = 1'b1;
      step();
      dbg_starve_clr = 1'b0;
      n_cmp++; if (dbg_starve !== 1'b0) begin n_bad++; $display("FAIL starve_clr got %b exp 0", dbg_starve); end
   endtask

   task automatic test_back_to_back();
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_a = 8'h01; dbg_be = 4'hF; dbg_wd = 32'hAAAA0000;
      step();
      dbg_req = 1'b0; dat_a = 16'h0008; dat_we = 4'hF; dat_wd = 32'h0000BBBB;
      step();
      dat_we = 4'h0;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_a = 8'h01;
      #1;
      n_cmp++; if (dbg_gnt !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt got %b exp 1", dbg_gnt); end
      step();
      n_cmp++; if (dbg_rvalid !== 1'b1 || dbg_rd !== 32'hAAAA0000) begin
         n_bad++; $display("FAIL b2b_dbg_ret got v=%b rd=%h exp 1/AAAA0000", dbg_rvalid, dbg_rd); end
      dbg_req = 1'b0; dat_a = 16'h0008; dat_re = 4'hF;
      step();
      dat_re = 4'h0;
      n_cmp++; if (dat_rd !== 32'h0000BBBB || dbg_rvalid !== 1'b0) begin
         n_bad++; $display("FAIL b2b_core_ret got rd=%h v=%b exp 0000BBBB/0", dat_rd, dbg_rvalid); end
      step();
   endtask

   task automatic test_reset_pending();
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_a = 8'h01; dbg_be = 4'hF;
      #1;
      n_cmp++; if (dbg_gnt !== 1'b1) begin n_bad++; $display("FAIL rst_pend_gnt got %b exp 1", dbg_gnt); end
      #1 rstn = 1'b0;
      #1;
      n_cmp++; if (sram_re !== 4'h0 || sram_we !== 4'h0) begin
         n_bad++; $display("FAIL rst_force_re got re=%h we=%h exp 0/0", sram_re, sram_we); end
      step();
      dat_we = 4'hF; dat_a = 16'h0010;
      #1;
      n_cmp++; if (sram_we !== 4'h0) begin n_bad++; $display("FAIL rst_force_we got %h exp 0", sram_we); end
      n_cmp++; if (dbg_rvalid !== 1'b0 || dat_rd !== 32'h0 || dbg_rd !== 32'h0 || dbg_starve !== 1'b0) begin
         n_bad++; $display("FAIL rst_outputs got v=%b crd=%h drd=%h st=%b exp 0/0/0/0", dbg_rvalid, dat_rd, dbg_rd, dbg_starve); end
`ifdef DSRAM_ARB_STAT_EN
      n_cmp++; if (stat_core !== 32'h0 || stat_dbg !== 32'h0 || stat_conf !== 32'h0) begin
         n_bad++; $display("FAIL rst_stats got %h/%h/%h exp 0/0/0", stat_core, stat_dbg, stat_conf); end
`endif
      idle_inputs();
      rstn = 1'b1;
      #1;
      n_cmp++; if (sram_a !== 8'h00 || sram_wd !== 32'h0) begin
         n_bad++; $display("FAIL rst_hold_regs got a=%h wd=%h exp 00/0", sram_a, sram_wd); end
      step();
      n_cmp++; if (dbg_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_no_return got %b exp 0", dbg_rvalid); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      sram_rd = 32'h0;
      rstn = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      #1;
      test_reset();
      step();
      test_core_rw();
      test_idle_dbg();
      test_conflict();
      test_starve();
      test_back_to_back();
      test_reset_pending();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
